mac_vec_acc: RTL and testbench
==============================

// Module: mac_vec_acc
// PURPOSE
//  Multi-lane dot-product multiply-accumulate engine; successor to the single-lane 16-bit MAC.
//  Each accepted beat carries LANES operand pairs. Their products are summed and accumulated
//  over a programmed number of beats (len).
//  Adds a valid/ready input and output, a signed/unsigned mode, saturation, a job length
//  counter and a sync abort. Sits between the operand fetch stream and the result writeback.
// PARAMETERS
//  IN_WIDTH   16  operand width per lane
//  LANES      4   operand pairs per beat (>=1)
//  ACC_WIDTH  40  accumulator/result width (>= 2*IN_WIDTH+clog2(LANES))
//  LEN_WIDTH  8   width of beat-count field
// PORTS
//  clk          in   1                clock, rising edge
//  rst_n        in   1                async active-low reset
//  clear        in   1                sync abort: drop job, flush pipeline, go IDLE
//  start        in   1                begin job; sampled only in IDLE
//  len          in   LEN_WIDTH        beats in job; latched on start
//  signed_mode  in   1                1 = two's complement ops/acc; latched on start
//  in_valid     in   1                operand beat valid
//  in_ready     out  1                engine accepts beat
//  a            in   LANES*IN_WIDTH   lane i = a[i*IN_WIDTH +: IN_WIDTH]
//  b            in   LANES*IN_WIDTH   lane i = b[i*IN_WIDTH +: IN_WIDTH]
//  out_valid    out  1                result valid, held until out_ready
//  out_ready    in   1                consumer takes result
//  result       out  ACC_WIDTH        final accumulated value
//  sat_flag     out  1                job saturated at least once (sticky per job)
//  busy         out  1                state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; acc, result, lane-sum reg, counters = 0;
//    in_ready = out_valid = sat_flag = busy = 0.
//  - FSM states: IDLE, ACCUM, DRAIN, DONE.
//    IDLE->ACCUM on start with len!=0. IDLE->DONE on start with len==0: result=0, sat_flag=0.
//    ACCUM->DRAIN when the last beat is accepted.
//    DRAIN->DONE once the pipeline is empty.
//    DONE->IDLE on out_valid&out_ready.
//    clear in any state -> IDLE on the next edge: pipeline and acc zeroed, no result emitted.
//    clear has priority over start and all handshakes.
//  - start: acc=0, sat_flag=0, beat counter=len. start outside IDLE is ignored.
//  - in_ready = (state==ACCUM). A beat is accepted on an edge where in_valid&in_ready;
//    in_valid without in_ready has no effect. Gaps in in_valid are allowed.
//  - Pipeline:
//    edge k: accept beat; register lane_sum = sum of LANES products.
//    edge k+1: acc <= sat(acc + ext(lane_sum)).
//    edge k+2 (last beat only): DONE, out_valid=1, result=acc. Latency = 2 cycles after last accept.
//  - Widths: each product is 2*IN_WIDTH. lane_sum is 2*IN_WIDTH+clog2(LANES), exact with no overflow.
//    lane_sum is sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to ACC_WIDTH+1 for the add.
//  - Saturation:
//    signed: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//    unsigned: clamp to 2^ACC_WIDTH-1.
//    Any clamp sets sat_flag; further adds continue from the clamped value.
//  - DONE: result and sat_flag held stable while out_valid=1 and out_ready=0.
//    in_ready=0; start ignored. start in the same cycle as the output handshake is ignored.
//  - result and sat_flag keep their last value in IDLE until the next start or reset.
// TESTING
//  1 unsigned, len=1, a={4,3,2,1}, b={8,7,6,5} (lane3..0) -> result=70 two cycles after accept, sat_flag=0
//  2 signed, len=3, all a=-1, b=2, in_valid gaps between beats -> result=-24 (0xFFFFFFFFE8), sat_flag=0
//  3 signed, len=255, all a=b=-32768 -> each beat +2^32; result=2^39-1 after beat 128, sat_flag=1
//  4 out_ready low 5 cycles in DONE, start and in_valid pulsed -> result stable, in_ready=0, no new job
//  5 start with len=0 -> out_valid next cycle, result=0; handshake -> IDLE, busy=0
//  6 rst_n low, then clear, mid-ACCUM -> in_ready=0, out_valid=0, no result; following job as test 1 gives 70

Source files
------------

// File: rtl/mac_vec_acc.sv
// Multi-lane dot-product multiply-accumulate engine with valid/ready streams,
// signed/unsigned mode, saturating accumulator, job length counter and sync abort.
module mac_vec_acc #(
    parameter int IN_WIDTH  = 16,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic                         signed_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_WIDTH-1:0]    a,
    input  logic [LANES*IN_WIDTH-1:0]    b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         result,
    output logic                         sat_flag,
    output logic                         busy
);

    // state  | meaning
    // IDLE   | waiting for start; last result/sat_flag held
    // ACCUM  | accepting operand beats until the beat counter runs out
    // DRAIN  | last beat accepted, waiting for the final accumulate
    // DONE   | result presented, waiting for out_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int LOG_L = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = 2 * IN_WIDTH;
    localparam int LS_W  = PW + LOG_L;
    localparam int SW    = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] MAX_S = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_S = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] MAX_U = {ACC_WIDTH{1'b1}};

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LS_W-1:0]      lane_sum_q, lane_sum_d;
    logic                 ls_valid_q, ls_valid_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 signed_q, signed_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 sat_q, sat_d;

    logic [LS_W-1:0]      lane_sum_c;
    logic [IN_WIDTH-1:0]  a_l, b_l;
    logic [PW-1:0]        a_x, b_x, prod;

    // Products are formed on extended operands; the low PW bits are exact in either mode.
    always_comb begin
        lane_sum_c = '0;
        a_l        = '0;
        b_l        = '0;
        a_x        = '0;
        b_x        = '0;
        prod       = '0;
        for (int i = 0; i < LANES; i++) begin
            a_l        = a[i*IN_WIDTH +: IN_WIDTH];
            b_l        = b[i*IN_WIDTH +: IN_WIDTH];
            a_x        = {{IN_WIDTH{signed_q & a_l[IN_WIDTH-1]}}, a_l};
            b_x        = {{IN_WIDTH{signed_q & b_l[IN_WIDTH-1]}}, b_l};
            prod       = a_x * b_x;
            lane_sum_c = lane_sum_c + {{LOG_L{signed_q & prod[PW-1]}}, prod};
        end
    end

    logic [SW-1:0]        ext_sum, acc_x, sum_x;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] acc_add;

    always_comb begin
        ext_sum = {{(SW-LS_W){signed_q & lane_sum_q[LS_W-1]}}, lane_sum_q};
        acc_x   = {signed_q & acc_q[ACC_WIDTH-1], acc_q};
        sum_x   = acc_x + ext_sum;
        acc_add = sum_x[ACC_WIDTH-1:0];
        if (signed_q) begin
            ovf = sum_x[SW-1] ^ sum_x[SW-2];
            if (ovf) acc_add = sum_x[SW-1] ? MIN_S : MAX_S;
        end else begin
            ovf = sum_x[SW-1];
            if (ovf) acc_add = MAX_U;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        lane_sum_d = lane_sum_q;
        ls_valid_d = 1'b0;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        result_d   = result_q;
        sat_d      = sat_q;
        if (clear) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            lane_sum_d = '0;
            cnt_d      = '0;
        end else begin
            if (ls_valid_q) begin
                acc_d = acc_add;
                if (ovf) sat_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        signed_d = signed_mode;
                        acc_d    = '0;
                        sat_d    = 1'b0;
                        cnt_d    = len;
                        if (len == '0) begin
                            state_d  = S_DONE;
                            result_d = '0;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        lane_sum_d = lane_sum_c;
                        ls_valid_d = 1'b1;
                        cnt_d      = cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!ls_valid_q) begin
                        state_d  = S_DONE;
                        result_d = acc_q;
                    end
                end
                default: begin
                    if (out_ready) state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            lane_sum_q <= '0;
            ls_valid_q <= 1'b0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            lane_sum_q <= lane_sum_d;
            ls_valid_q <= ls_valid_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
            sat_q      <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed bench for mac_vec_acc: hand-computed dot products, saturation,
// output back-pressure, zero-length jobs, reset and clear mid-job.
module tb_mac_vec_acc;

    localparam int IW = 16;
    localparam int L  = 4;
    localparam int AW = 40;
    localparam int LW = 8;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            start;
    logic [LW-1:0]   len;
    logic            signed_mode;
    logic            in_valid;
    logic            in_ready;
    logic [L*IW-1:0] a;
    logic [L*IW-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   result;
    logic            sat_flag;
    logic            busy;

    int total = 0;
    int bad   = 0;

    mac_vec_acc #(.IN_WIDTH(IW), .LANES(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .len(len),
        .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_flag(sat_flag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [LW-1:0] n, input logic sm);
        start       = 1'b1;
        len         = n;
        signed_mode = sm;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [L*IW-1:0] av, input logic [L*IW-1:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic job_70(input string tag);
        do_start(8'd1, 1'b0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5});
        chk({tag, "_drain_in_ready"}, 64'(in_ready), 64'd0);
        tick();
        chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, 64'(result), 64'd70);
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
        handshake();
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_result"}, 64'(result), 64'd70);
    endtask

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        start       = 1'b0;
        len         = '0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        tick();

        // unsigned single-beat dot product
        job_70("t1");

        // signed, 3 beats with gaps: 4 lanes * (-1*2) * 3 = -24
        do_start(8'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            beat({4{16'hFFFF}}, {4{16'd2}});
            tick();
        end
        tick();
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_result", 64'(result), 64'h00_FFFF_FFFF_E8);
        chk("t2_sat", 64'(sat_flag), 64'd0);

        // held in DONE with start/in_valid activity
        for (int i = 0; i < 5; i++) begin
            start    = i[0];
            len      = 8'd2;
            in_valid = ~i[0];
            a        = {4{16'd1}};
            b        = {4{16'd1}};
            tick();
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_result", 64'(result), 64'h00_FFFF_FFFF_E8);
            chk("t4_in_ready", 64'(in_ready), 64'd0);
        end
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("t4_after_hs_busy", 64'(busy), 64'd0);
        tick();
        chk("t4_no_new_job", 64'(busy), 64'd0);
        chk("t4_result_kept", 64'(result), 64'h00_FFFF_FFFF_E8);

        // signed saturation: each beat adds 4 * 2^30 = 2^32
        do_start(8'd255, 1'b1);
        a        = {4{16'h8000}};
        b        = {4{16'h8000}};
        in_valid = 1'b1;
        for (int i = 0; i < 127; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t3_sat_before", 64'(sat_flag), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        beat({4{16'h8000}}, {4{16'h8000}});
        tick();
        chk("t3_sat_at_128", 64'(sat_flag), 64'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 127; i++) tick();
        in_valid = 1'b0;
        chk("t3_drain_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_result", 64'(result), 64'h00_7F_FFFF_FFFF);
        chk("t3_sat", 64'(sat_flag), 64'd1);
        handshake();

        // zero-length job
        do_start(8'd0, 1'b0);
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_result", 64'(result), 64'd0);
        chk("t5_sat", 64'(sat_flag), 64'd0);
        handshake();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);

        // async reset mid-ACCUM
        do_start(8'd3, 1'b0);
        beat({4{16'd9}}, {4{16'd9}});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // clear mid-ACCUM
        do_start(8'd3, 1'b0);
        beat({4{16'd9}}, {4{16'd9}});
        beat({4{16'd9}}, {4{16'd9}});
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("t6_clr_in_ready", 64'(in_ready), 64'd0);
        chk("t6_clr_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_clr_out_valid", 64'(out_valid), 64'd0);
        end
        chk("t6_clr_result", 64'(result), 64'd0);

        job_70("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
